// File: rtl/pulse_stretch_pkg.sv
// Shared timing definitions for the UI output stretcher: state codes, counter width, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pulse_stretch_pkg;

  // Per-channel state codes. 2'd3 is unused; any channel that lands there returns to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } ui_state_e;

  // Tick counter width. It is shared with the debouncer and bounds HOLD/GAP to 1..255 ticks.
  localparam int UI_CTR_W = 8;

  // Counter value that marks the final tick of a phase lasting 'ticks' tick_en periods.
  function automatic logic [UI_CTR_W-1:0] last_count(input int ticks);
    return UI_CTR_W'(ticks - 1);
  endfunction

endpackage : pulse_stretch_pkg

// File: rtl/pulse_stretch_if.sv
// Bundle of the stretcher's strobe, event inputs and stretched outputs (one bit per channel).
// Latency: n/a (wiring only).
// Backpressure: none. Events are fire-and-forget single-clk pulses.
interface pulse_stretch_if #(
  parameter int WIDTH = 1
);

  logic             tick_en;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] busy;

  // Event source side: the control logic and strobe generator.
  modport master (
    output tick_en,
    output ev,
    input  dout,
    input  busy
  );

  // Stretcher side.
  modport slave (
    input  tick_en,
    input  ev,
    output dout,
    output busy
  );

endinterface : pulse_stretch_if

// File: rtl/pulse_stretch_1bit.sv
// One channel: a single-clk event becomes HOLD ticks of high output, followed by GAP ticks forced low.
// Latency: 1 clk from ev in idle to dout high. Outputs are registered and are decoded from the next state.
// Backpressure: none. Events during HOLD or GAP coalesce into one pending bit, or restart HOLD when PULSE_STRETCH_RETRIGGER_EN is defined.
module pulse_stretch_1bit
  import pulse_stretch_pkg::*;
#(
  parameter int HOLD_TICKS = 100,
  parameter int GAP_TICKS  = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic ev,
  output logic dout,
  output logic busy
);

  localparam logic [UI_CTR_W-1:0] HOLD_LAST = last_count(HOLD_TICKS);
  localparam logic [UI_CTR_W-1:0] GAP_LAST  = last_count(GAP_TICKS);

  ui_state_e             state_q, state_d;
  logic [UI_CTR_W-1:0]   ctr_q, ctr_d;
  logic                  pending_q, pending_d;
  logic                  dout_q, dout_d;
  logic                  busy_q, busy_d;

  // Next-state logic. The counter is cleared on every phase entry, so it never passes the phase's last value.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    pending_d = pending_q;

    case (state_q)
      ST_IDLE: begin
        // A tick_en in the same cycle as the event is not counted toward HOLD.
        if (ev) begin
          state_d = ST_HOLD;
          ctr_d   = '0;
        end
      end

      ST_HOLD: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        // A new event restarts the on-time. It wins over a coincident terminating tick.
        if (ev) begin
          ctr_d = '0;
        end else if (tick_en) begin
          if (ctr_q == HOLD_LAST) begin
            state_d = ST_GAP;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
`else
        // The event is remembered and replayed after the gap. The current pulse keeps its length.
        if (ev) begin
          pending_d = 1'b1;
        end
        if (tick_en) begin
          if (ctr_q == HOLD_LAST) begin
            state_d = ST_GAP;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
`endif
      end

      ST_GAP: begin
        if (ev) begin
          pending_d = 1'b1;
        end
        if (tick_en) begin
          if (ctr_q == GAP_LAST) begin
            ctr_d     = '0;
            pending_d = 1'b0;
            // An event that arrives with the final gap tick still counts. It goes straight back to HOLD.
            if (pending_q || ev) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        ctr_d     = '0;
        pending_d = 1'b0;
      end
    endcase

    dout_d = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
  end

  // Channel state and registered outputs. Reset aborts any pulse and drops a pending event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ctr_q     <= '0;
      pending_q <= 1'b0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      pending_q <= pending_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;

endmodule : pulse_stretch_1bit

// File: rtl/pulse_stretch.sv
// WIDTH independent pulse stretchers driven by a shared tick_en strobe. Option macro: PULSE_STRETCH_RETRIGGER_EN.
// Latency: 1 clk from ev to dout. dout and busy are registered.
// Backpressure: none. Each channel absorbs extra events itself (coalesce-and-replay, or retrigger with the macro).
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int HOLD_TICKS = 100,
  parameter int GAP_TICKS  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  pulse_stretch_if.slave    io
);

  // The tick counter is UI_CTR_W bits wide, so both phase lengths must fit in 1..255.
  if (HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_hold
    $error("pulse_stretch: HOLD_TICKS out of range 1..255");
  end
  if (GAP_TICKS < 1 || GAP_TICKS > 255) begin : g_bad_gap
    $error("pulse_stretch: GAP_TICKS out of range 1..255");
  end

  logic [WIDTH-1:0] dout_w;
  logic [WIDTH-1:0] busy_w;

  // One stretcher per channel. Channels share only clk, rst_n and tick_en.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pulse_stretch_1bit #(
      .HOLD_TICKS (HOLD_TICKS),
      .GAP_TICKS  (GAP_TICKS)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_en (io.tick_en),
      .ev      (io.ev[i]),
      .dout    (dout_w[i]),
      .busy    (busy_w[i])
    );
  end

  assign io.dout = dout_w;
  assign io.busy = busy_w;

endmodule : pulse_stretch

// File: tb/tb_pulse_stretch.sv
// Randomized and directed bench for pulse_stretch, using a per-channel remaining-ticks reference model and a cycle scoreboard.
// Latency: expected outputs are queued one clk ahead and compared 1 time unit after each rising edge.
// Backpressure: none. The driver pushes exactly one expectation per cycle.
module tb_pulse_stretch;

  localparam int WIDTH = 4;
  localparam int HOLD  = 3;
  localparam int GAP   = 2;
`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk;
  logic rst_n;

  pulse_stretch_if #(.WIDTH(WIDTH)) io ();

  pulse_stretch #(
    .WIDTH      (WIDTH),
    .HOLD_TICKS (HOLD),
    .GAP_TICKS  (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ticks still to go in each phase, plus a remembered-event flag.
  int hold_rem [WIDTH];
  int gap_rem  [WIDTH];
  bit pend     [WIDTH];

  logic [2*WIDTH-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_mode = 0;  // 0: every 4th clk, 1: every clk, 2: random

  function automatic void model_reset();
    for (int c = 0; c < WIDTH; c++) begin
      hold_rem[c] = 0;
      gap_rem[c]  = 0;
      pend[c]     = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic [WIDTH-1:0] e, input logic t);
    for (int c = 0; c < WIDTH; c++) begin
      if (hold_rem[c] > 0) begin
        if (RETRIG && e[c]) begin
          hold_rem[c] = HOLD;
        end else begin
          if (e[c]) pend[c] = 1'b1;
          if (t) begin
            hold_rem[c] = hold_rem[c] - 1;
            if (hold_rem[c] == 0) gap_rem[c] = GAP;
          end
        end
      end else if (gap_rem[c] > 0) begin
        if (e[c]) pend[c] = 1'b1;
        if (t) begin
          gap_rem[c] = gap_rem[c] - 1;
          if (gap_rem[c] == 0 && pend[c]) begin
            hold_rem[c] = HOLD;
            pend[c]     = 1'b0;
          end
        end
      end else if (e[c]) begin
        hold_rem[c] = HOLD;
      end
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] model_out();
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] b;
    for (int c = 0; c < WIDTH; c++) begin
      d[c] = (hold_rem[c] > 0);
      b[c] = (hold_rem[c] > 0) || (gap_rem[c] > 0);
    end
    return {d, b};
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  // One cycle of stimulus. Inputs change on the falling edge. r=0 holds the block in reset for this cycle.
  task automatic drive(input logic [WIDTH-1:0] e, input logic r);
    logic t;
    @(negedge clk);
    case (tick_mode)
      0:       t = (cyc % 4 == 3);
      1:       t = 1'b1;
      default: t = ($urandom_range(0, 2) == 0);
    endcase
    io.ev      = e;
    io.tick_en = t;
    if (!r) begin
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_dout", io.dout, '0);
      chk("async_rst_busy", io.busy, '0);
    end else begin
      rst_n = 1'b1;
      model_step(e, t);
    end
    exp_q.push_back(model_out());
    cyc++;
  endtask

  // Directed sequence on one channel. Bit k of the map puts an event at offset k; offsets 3, 7, 11, ... are ticks.
  task automatic seq(input int ch, input logic [63:0] map, input int rst_off);
    logic [63:0] m;
    logic [WIDTH-1:0] e;
    m = map;
    while (cyc % 4 != 0) drive('0, 1'b1);
    for (int k = 0; k < 64; k++) begin
      e = '0;
      e[ch] = m[k];
      drive(e, !(k == rst_off || k == rst_off + 1));
    end
  endtask

  function automatic logic [63:0] bits2(input int a, input int b);
    return (64'd1 << a) | (64'd1 << b);
  endfunction

  // Monitor: compare the DUT outputs against the queued expectation after each rising edge.
  initial begin
    logic [2*WIDTH-1:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("dout", io.dout, x[2*WIDTH-1:WIDTH]);
        chk("busy", io.busy, x[WIDTH-1:0]);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] e;
    rst_n      = 1'b1;
    io.ev      = '1;
    io.tick_en = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_dout", io.dout, '0);
    chk("reset_busy", io.busy, '0);

    // Reset held while events arrive. Then release with an event in the same cycle.
    for (int i = 0; i < 3; i++) drive('1, 1'b0);
    drive(4'b0001, 1'b1);
    for (int i = 0; i < 48; i++) drive('0, 1'b1);

    tick_mode = 0;
    seq(0, bits2(0, 0), -10);                           // single event
    seq(0, bits2(0, 1), -10);                           // event right after HOLD entry
    seq(1, bits2(0, 2) | bits2(5, 9), -10);             // several events in one HOLD
    seq(2, bits2(0, 7), -10);                           // event on the 2nd HOLD tick
    seq(3, bits2(0, 19), -10);                          // event on the final GAP tick
    seq(0, bits2(0, 11), -10);                          // event on the final HOLD tick
    seq(1, bits2(0, 2), 5);                             // reset mid-HOLD with an event pending

    // Random traffic on all channels with regular, continuous and random ticks.
    for (int ph = 0; ph < 3; ph++) begin
      tick_mode = ph;
      for (int i = 0; i < 500; i++) begin
        for (int c = 0; c < WIDTH; c++) e[c] = ($urandom_range(0, 11) == 0);
        drive(e, !(ph == 2 && $urandom_range(0, 199) == 0));
      end
    end
    tick_mode = 0;
    for (int i = 0; i < 4; i++) drive('0, 1'b1);
    @(posedge clk);
    #3;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pulse_stretch
